// File: rtl/mac_accumulator_4_pkg.sv
// Package for the MAC accumulator: FSM state type and default sizes,
// all derived from the shared mac_defs.vh constants.
`include "mac_defs.vh"

package mac_accumulator_4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = `MAC_ST_IDLE,
        ST_ACC  = `MAC_ST_ACC,
        ST_HOLD = `MAC_ST_HOLD
    } mac_state_t;

    localparam int MAC_ACC_W_DEF = `MAC_ACC_W_DEF;
    localparam int MAC_N_MAX_DEF = `MAC_N_MAX_DEF;

endpackage

// File: rtl/mac_defs.vh
// Shared constants for the 4x4 MAC accumulator: FSM encodings and
// default parameter values.
`ifndef MAC_DEFS_VH
`define MAC_DEFS_VH

`define MAC_ST_IDLE      2'd0
`define MAC_ST_ACC       2'd1
`define MAC_ST_HOLD      2'd2

`define MAC_ACC_W_DEF    12
`define MAC_N_MAX_DEF    16

`endif

// File: rtl/multiplier_4.sv
// Unsigned 4x4 multiplier built from shifted partial products and adders.
module multiplier_4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] product
);

    logic [7:0] w_pp0;
    logic [7:0] w_pp1;
    logic [7:0] w_pp2;
    logic [7:0] w_pp3;

    // Each partial product is A gated by one bit of B, shifted into place.
    always_comb begin
        w_pp0   = {4'b0000, A & {4{B[0]}}};
        w_pp1   = {3'b000, A & {4{B[1]}}, 1'b0};
        w_pp2   = {2'b00, A & {4{B[2]}}, 2'b00};
        w_pp3   = {1'b0, A & {4{B[3]}}, 3'b000};
        product = w_pp0 + w_pp1 + w_pp2 + w_pp3;
    end

endmodule

// File: rtl/mac_accumulator_4.sv
// Multiply-accumulate over groups of up to N_MAX terms. Each accepted term
// adds A*B to the accumulator; a term with last=1, or the N_MAX-th term,
// closes the group and the result is held until the consumer takes it.
//
// Handshake: a term transfers on a rising edge with in_valid && in_ready;
// a result transfers on a rising edge with out_valid && out_ready. Both
// sides may hold valid without waiting for ready, and outputs stay stable
// while valid is high and ready is low.
module mac_accumulator_4
    import mac_accumulator_4_pkg::*;
#(
    parameter int ACC_W = MAC_ACC_W_DEF,
    parameter int N_MAX = MAC_N_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       A,
    input  logic [3:0]       B,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] Y,
    output logic [4:0]       count,
    output logic             overflow,
    output logic [1:0]       o_dbg_state
);

    localparam logic [4:0] N_MAX_C = 5'(N_MAX);

    mac_state_t       r_state;
    mac_state_t       w_state_next;
    logic [ACC_W-1:0] r_acc;
    logic [4:0]       r_count;
    logic             r_ovf;

    logic [7:0]       w_prod;
    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W-1:0] w_base;
    logic [ACC_W:0]   w_sum;
    logic [4:0]       w_count_next;
    logic             w_first;
    logic             w_accept;
    logic             w_close;
    logic             w_release;

    multiplier_4 u_mult (
        .A       (A),
        .B       (B),
        .product (w_prod)
    );

    // Handshake decode and the next accumulator/count values for a term.
    always_comb begin
        in_ready     = (r_state != ST_HOLD);
        out_valid    = (r_state == ST_HOLD);
        w_accept     = in_valid && in_ready;
        w_release    = out_valid && out_ready;
        w_first      = (r_state == ST_IDLE);
        w_prod_ext   = '0;
        w_prod_ext[7:0] = w_prod;
        // The first term of a group loads rather than adds.
        w_base       = w_first ? '0 : r_acc;
        w_sum        = {1'b0, w_base} + {1'b0, w_prod_ext};
        w_count_next = w_first ? 5'd1 : (r_count + 5'd1);
        w_close      = last || (w_count_next == N_MAX_C);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_ACC: begin
                if (w_accept) begin
                    w_state_next = w_close ? ST_HOLD : ST_ACC;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath registers: update on an accepted term, clear on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_release) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= w_sum[ACC_W-1:0];
            r_count <= w_count_next;
            r_ovf   <= (w_first ? 1'b0 : r_ovf) | w_sum[ACC_W];
        end
    end

    // Result outputs come straight from the registers so they hold in HOLD.
    always_comb begin
        Y           = r_acc;
        count       = r_count;
        overflow    = r_ovf;
        o_dbg_state = r_state;
    end

endmodule

// File: tb/tb_mac_accumulator_4.sv
// Directed bench for mac_accumulator_4: a default-width instance and an
// 8-bit-accumulator instance share one stimulus stream.
module tb_mac_accumulator_4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  A;
    logic [3:0]  B;
    logic        last;
    logic        out_ready;

    logic        in_ready_w;
    logic        out_valid_w;
    logic [11:0] y_w;
    logic [4:0]  count_w;
    logic        ovf_w;
    logic [1:0]  st_w;

    logic        in_ready_n;
    logic        out_valid_n;
    logic [7:0]  y_n;
    logic [4:0]  count_n;
    logic        ovf_n;
    logic [1:0]  st_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mac_accumulator_4 dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .A(A), .B(B), .last(last), .out_valid(out_valid_w),
        .out_ready(out_ready), .Y(y_w), .count(count_w),
        .overflow(ovf_w), .o_dbg_state(st_w)
    );

    mac_accumulator_4 #(.ACC_W(8), .N_MAX(16)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
        .A(A), .B(B), .last(last), .out_valid(out_valid_n),
        .out_ready(out_ready), .Y(y_n), .count(count_n),
        .overflow(ovf_n), .o_dbg_state(st_n)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic term(input logic [3:0] a, input logic [3:0] b,
                        input logic l);
        in_valid = 1'b1;
        A        = a;
        B        = b;
        last     = l;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        A        = 4'd0;
        B        = 4'd0;
        last     = 1'b0;
    endtask

    task automatic check_clear(input string tag);
        check({tag, "_ov"}, 32'(out_valid_w), 32'd0);
        check({tag, "_ir"}, 32'(in_ready_w), 32'd1);
        check({tag, "_y"}, 32'(y_w), 32'd0);
        check({tag, "_cnt"}, 32'(count_w), 32'd0);
        check({tag, "_ovf"}, 32'(ovf_w), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        idle_in();
        #1;
        check_clear("rst_hold");
        check("rst_state", 32'(st_w), 32'd0);
        #12;
        rst = 1'b0;
        tick();
        check_clear("post_rst");

        // Three-term group: 15 + 225 + 0 = 240.
        term(4'd3, 4'd5, 1'b0);
        tick();
        check("g3_ov_t1", 32'(out_valid_w), 32'd0);
        check("g3_cnt_t1", 32'(count_w), 32'd1);
        term(4'd15, 4'd15, 1'b0);
        tick();
        term(4'd0, 4'd9, 1'b1);
        tick();
        idle_in();
        check("g3_ov", 32'(out_valid_w), 32'd1);
        check("g3_y", 32'(y_w), 32'd240);
        check("g3_cnt", 32'(count_w), 32'd3);
        check("g3_ovf", 32'(ovf_w), 32'd0);
        check("g3_ir", 32'(in_ready_w), 32'd0);
        check("g3_y8", 32'(y_n), 32'd240);
        tick();
        check_clear("g3_after");

        // Sixteen 15x15 terms without last: group forced closed at N_MAX.
        term(4'd15, 4'd15, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        check("n16_ov_15", 32'(out_valid_w), 32'd0);
        check("n16_cnt_15", 32'(count_w), 32'd15);
        tick();
        idle_in();
        check("n16_ov", 32'(out_valid_w), 32'd1);
        check("n16_y", 32'(y_w), 32'd3600);
        check("n16_cnt", 32'(count_w), 32'd16);
        check("n16_ovf", 32'(ovf_w), 32'd0);
        check("n16_y8", 32'(y_n), 32'd16);
        check("n16_ovf8", 32'(ovf_n), 32'd1);
        tick();
        check_clear("n16_after");

        // 15x15 then 2x4 (20 truncated to 4 bits): 225 + 8 = 233.
        term(4'd15, 4'd15, 1'b0);
        tick();
        term(4'd2, 4'(20), 1'b1);
        tick();
        idle_in();
        check("m8_y8", 32'(y_n), 32'd233);
        check("m8_ovf8", 32'(ovf_n), 32'd0);
        check("m8_y", 32'(y_w), 32'd233);
        tick();

        // 225 + 225 = 450: wraps to 194 in 8 bits with overflow.
        term(4'd15, 4'd15, 1'b0);
        tick();
        term(4'd15, 4'd15, 1'b1);
        tick();
        idle_in();
        check("wr_y8", 32'(y_n), 32'd194);
        check("wr_ovf8", 32'(ovf_n), 32'd1);
        check("wr_y", 32'(y_w), 32'd450);
        check("wr_ovf", 32'(ovf_w), 32'd0);
        tick();
        term(4'd1, 4'd1, 1'b1);
        tick();
        idle_in();
        check("nx_y8", 32'(y_n), 32'd1);
        check("nx_ovf8", 32'(ovf_n), 32'd0);
        check("nx_cnt8", 32'(count_n), 32'd1);
        tick();

        // Held result with back-pressure while a new term waits.
        out_ready = 1'b0;
        term(4'd2, 4'd3, 1'b1);
        tick();
        term(4'd4, 4'd5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_y", 32'(y_w), 32'd6);
            check("bp_ir", 32'(in_ready_w), 32'd0);
            check("bp_ov", 32'(out_valid_w), 32'd1);
        end
        check("bp_cnt", 32'(count_w), 32'd1);
        out_ready = 1'b1;
        tick();
        check_clear("bp_rel");
        tick();
        idle_in();
        check("bp_next_ov", 32'(out_valid_w), 32'd1);
        check("bp_next_y", 32'(y_w), 32'd20);
        check("bp_next_cnt", 32'(count_w), 32'd1);
        check("bp_next_st", 32'(st_w), 32'd2);
        tick();

        // Asynchronous reset mid-group discards the partial sum.
        term(4'd1, 4'd2, 1'b0);
        tick();
        term(4'd3, 4'd4, 1'b0);
        tick();
        idle_in();
        check("ar_cnt_pre", 32'(count_w), 32'd2);
        check("ar_st_pre", 32'(st_w), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_clear("ar_async");
        #1;
        rst = 1'b0;
        tick();
        term(4'd7, 4'd3, 1'b1);
        tick();
        idle_in();
        check("ar_y", 32'(y_w), 32'd21);
        check("ar_cnt", 32'(count_w), 32'd1);
        check("ar_ov", 32'(out_valid_w), 32'd1);
        tick();
        check_clear("ar_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
